alu_req_driver: RTL
===================

ALU_REQ_DRIVER -- requirements
Module: alu_req_driver

Interface
REQ-001 The block SHALL have one parameter: ALU_LATENCY, default 1, rising edges from ALU operand capture to a valid ALU result (legal 1..7).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  upstream request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_opcode  in  2  requested ALU operation.
REQ-008 req_a  in  4  operand A, signed two's complement.
REQ-009 req_b  in  4  operand B, signed two's complement.
REQ-010 alu_opcode  out  2  opcode driven to the ALU.
REQ-011 alu_a  out  4  operand A driven to the ALU, signed.
REQ-012 alu_b  out  4  operand B driven to the ALU, signed.
REQ-013 alu_c  in  5  ALU result, signed.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  downstream accepts response.
REQ-016 rsp_result  out  5  captured ALU result, signed.
REQ-017 rsp_opcode  out  2  opcode of the transaction being responded.
REQ-018 rsp_mismatch  out  1  captured result differs from the internal expected value.
REQ-019 mismatch_count  out  8  mismatches seen; saturates at 255.
REQ-020 op_count  out  8  completed response handshakes; wraps 255 -> 0.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; acceptance is req_valid && req_ready on a rising edge.
REQ-023 On acceptance, alu_opcode/alu_a/alu_b SHALL load req_opcode/req_a/req_b, the FSM SHALL enter WAIT, and the wait counter SHALL load ALU_LATENCY.
REQ-024 alu_opcode/alu_a/alu_b SHALL hold unchanged from acceptance until the next acceptance, including through RESP and IDLE.
REQ-025 In WAIT, the counter SHALL decrement each edge; on the edge where it is 0, alu_c SHALL be captured into rsp_result, rsp_valid SHALL be set, and the FSM SHALL enter RESP; this is the (ALU_LATENCY+1)th edge after acceptance.
REQ-026 The expected value SHALL be computed from the held operands: 00 -> A+B sign-extended to 5 bits; 01 -> A-B sign-extended to 5 bits; 10 -> bitwise NOT of A, sign-extended; 11 -> OR-reduction of B, zero-extended (0 or 1).
REQ-027 rsp_mismatch SHALL be set on the capture edge if alu_c (compared with !==, so X/Z counts as mismatch) differs from the expected value; mismatch_count SHALL increment on that same edge unless already 255.
REQ-028 In RESP, rsp_valid, rsp_result, rsp_opcode and rsp_mismatch SHALL hold stable until rsp_ready is 1.
REQ-029 On rsp_valid && rsp_ready: rsp_valid SHALL clear, op_count SHALL increment (255 wraps to 0), and the FSM SHALL return to IDLE; rsp_result/rsp_opcode/rsp_mismatch hold their last values.
REQ-030 A request is never accepted in the same cycle as a response handshake; minimum issue period is ALU_LATENCY+3 cycles.
REQ-031 rsp_ready while rsp_valid=0, or req_valid outside IDLE, SHALL have no effect.

Reset
REQ-032 While reset=1 on an edge, the FSM SHALL go to IDLE and every output SHALL become 0 except req_ready, which SHALL be 1; the wait counter SHALL clear.
REQ-033 Reset in WAIT or RESP SHALL abandon the transaction: no rsp_valid is produced for it, and neither counter is incremented.
REQ-034 Reset SHALL take priority over acceptance, capture and response handshake on the same edge.

Verification
REQ-035 Reset held 2 cycles -> all outputs 0, req_ready=1, state IDLE.
REQ-036 ALU_LATENCY=1, op 00, A=7, B=7 -> rsp_valid rises 2 edges after acceptance, rsp_result=14, rsp_mismatch=0, op_count=1 after handshake.
REQ-037 Ops 01 (A=-8, B=7), 10 (A=7), and 11 (A=0, B=-8), each against a correct ALU model -> results -15, -8 and 1, with mismatch_count staying 0.
REQ-038 rsp_ready held 0 for 3 cycles with req_valid=1 -> rsp_result stable, req_ready=0, no second acceptance; the second request is accepted one cycle after the handshake.
REQ-039 ALU model forced to return 0 for op 00, A=7, B=7 -> rsp_mismatch=1, mismatch_count=1; after 256 such mismatches, mismatch_count stays at 255.
REQ-040 Reset asserted in WAIT -> no rsp_valid, req_ready=1 next cycle, op_count=0; 256 completed transactions -> op_count=0.

Source files
------------

// File: rtl/alu_req_driver.sv
// Request driver for a fixed-latency ALU: accepts one request, holds operands on the
// ALU, captures its result after ALU_LATENCY+1 edges, checks it and hands it downstream.
module alu_req_driver #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_opcode,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic [1:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [4:0] alu_c,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_result,
  output logic [1:0] rsp_opcode,
  output logic       rsp_mismatch,
  output logic [7:0] mismatch_count,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_cnt;
  logic       w_accept;
  logic       w_capture;
  logic       w_done;
  logic       w_mismatch;
  logic [4:0] w_exp;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_capture = (r_state == WAIT) && (r_cnt == 3'd0);
  assign w_done    = (r_state == RESP) && rsp_valid && rsp_ready;
  // Case inequality so an X/Z result from the ALU is flagged rather than masked
  assign w_mismatch = (alu_c !== w_exp);

  always_comb begin
    w_exp = '0;
    unique case (alu_opcode)
      2'b00: w_exp = {alu_a[3], alu_a} + {alu_b[3], alu_b};
      2'b01: w_exp = {alu_a[3], alu_a} - {alu_b[3], alu_b};
      2'b10: w_exp = ~{alu_a[3], alu_a};
      2'b11: w_exp = {4'b0000, |alu_b};
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = WAIT;
      WAIT:    if (r_cnt == 3'd0) w_next = RESP;
      RESP:    if (rsp_valid && rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      alu_opcode     <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_opcode     <= '0;
      rsp_mismatch   <= 1'b0;
      mismatch_count <= '0;
      op_count       <= '0;
    end else begin
      if (w_accept) begin
        alu_opcode <= req_opcode;
        alu_a      <= req_a;
        alu_b      <= req_b;
        r_cnt      <= 3'(ALU_LATENCY);
      end else if ((r_state == WAIT) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_capture) begin
        rsp_valid    <= 1'b1;
        rsp_result   <= alu_c;
        rsp_opcode   <= alu_opcode;
        rsp_mismatch <= w_mismatch;
        if (w_mismatch && (mismatch_count != 8'hFF))
          mismatch_count <= mismatch_count + 8'd1;
      end
      if (w_done) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 8'd1;
      end
    end
  end

endmodule
